// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit.
package if_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_t;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts stalled WAIT cycles; expired flags the cycle whose edge reaches the limit.
module fetch_timeout_ctr #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic expired
);

   localparam int W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (en)
         count <= count + W'(1);
   end

   // A zero limit disables the timeout entirely.
   assign expired = (TIMEOUT_CYCLES != 0) && en && (count == LIMIT);

endmodule

// File: rtl/inst_fetch_unit.sv
// Multicycle CPU fetch unit: owns the PC, reads instruction memory, strobes IRWrite.
module inst_fetch_unit
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_start,
   input  logic        pc_load,
   input  logic [31:0] pc_next,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] inst,
   output logic        IRWrite,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        busy,
   output logic        err,
   output logic [1:0]  err_code
);

   state_t      state, state_d;
   logic [31:0] pc_d, inst_d, eff_addr;
   logic [1:0]  err_code_d;
   logic        timeout_expired;

   fetch_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (state != WAIT),
      .en      ((state == WAIT) && !mem_ready),
      .expired (timeout_expired)
   );

   assign eff_addr = pc_load ? pc_next : pc;

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d    = state;
      pc_d       = pc;
      inst_d     = inst;
      err_code_d = err_code;
      case (state)
         IDLE: begin
            if (fetch_start) begin
               pc_d = eff_addr;
               if (eff_addr[1:0] != 2'b00) begin
                  state_d    = ERR;
                  err_code_d = ERR_MISALIGN;
               end else begin
                  state_d = WAIT;
               end
            end else if (pc_load) begin
               pc_d = pc_next;
            end
         end
         WAIT: begin
            // Ready has priority over a timeout landing in the same cycle.
            if (mem_ready) begin
               inst_d  = mem_rdata;
               pc_d    = pc + 32'd4;
               state_d = DONE;
            end else if (timeout_expired) begin
               state_d    = ERR;
               err_code_d = ERR_TIMEOUT;
            end
         end
         DONE: state_d = IDLE;
         ERR: begin
            if (pc_load) begin
               pc_d       = pc_next;
               err_code_d = ERR_NONE;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: only control/datapath registers are reset here; there is no memory array to clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         inst     <= '0;
         err_code <= ERR_NONE;
      end else begin
         state    <= state_d;
         pc       <= pc_d;
         inst     <= inst_d;
         err_code <= err_code_d;
      end
   end

   // Outputs decode from state so an async reset drops mem_req at once.
   assign mem_req  = (state == WAIT);
   assign mem_addr = pc;
   assign busy     = (state == WAIT);
   assign IRWrite  = (state == DONE);
   assign err      = (state == ERR);
   assign pc_plus4 = pc + 32'd4;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit (TIMEOUT_CYCLES = 4).
module tb_inst_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_start, pc_load, mem_ready;
   logic [31:0] pc_next, mem_rdata;
   logic        mem_req, IRWrite, busy, err;
   logic [31:0] mem_addr, inst, pc, pc_plus4;
   logic [1:0]  err_code;

   int n_assert = 0;
   int n_fail   = 0;

   inst_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .fetch_start(fetch_start),
      .pc_load    (pc_load),
      .pc_next    (pc_next),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .inst       (inst),
      .IRWrite    (IRWrite),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .busy       (busy),
      .err        (err),
      .err_code   (err_code)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed no end of test, required finish before 100000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; fetch_start = 1'b0; pc_load = 1'b0; mem_ready = 1'b0;
      pc_next = '0; mem_rdata = '0;
      tick(); tick();
      rst = 1'b0;

      // Reset state
      check("rst_pc", pc, 32'h0);
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_inst", inst, 32'h0);
      check("rst_irwrite", IRWrite, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_err", {err, err_code}, 3'b000);

      // Normal fetch, ready two cycles after request
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      check("nf_req1", mem_req, 1'b1);
      check("nf_addr1", mem_addr, 32'h0);
      check("nf_busy", busy, 1'b1);
      check("nf_irw_wait", IRWrite, 1'b0);
      tick();
      check("nf_req2", mem_req, 1'b1);
      check("nf_addr2", mem_addr, 32'h0);
      mem_ready = 1'b1; mem_rdata = 32'h8C22_0004;
      tick();
      mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
      check("nf_irw", IRWrite, 1'b1);
      check("nf_inst", inst, 32'h8C22_0004);
      check("nf_pc", pc, 32'h4);
      check("nf_req_done", mem_req, 1'b0);
      tick();
      check("nf_irw_once", IRWrite, 1'b0);
      check("nf_inst_hold", inst, 32'h8C22_0004);

      // Jump load with simultaneous fetch
      pc_load = 1'b1; pc_next = 32'h0040_0010; fetch_start = 1'b1;
      tick();
      pc_load = 1'b0; fetch_start = 1'b0;
      check("jl_req", mem_req, 1'b1);
      check("jl_addr", mem_addr, 32'h0040_0010);
      mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
      tick();
      mem_ready = 1'b0;
      check("jl_irw", IRWrite, 1'b1);
      check("jl_pc", pc, 32'h0040_0014);
      check("jl_inst", inst, 32'h1234_5678);
      tick();

      // Misaligned fetch, ERR ignores fetch_start, recovery by pc_load
      pc_load = 1'b1; pc_next = 32'h0000_0006;
      tick();
      pc_load = 1'b0;
      check("ma_pc_loaded", pc, 32'h6);
      check("ma_no_err_yet", err, 1'b0);
      fetch_start = 1'b1;
      tick();
      check("ma_err", err, 1'b1);
      check("ma_code", err_code, 2'b01);
      check("ma_no_req", mem_req, 1'b0);
      tick();
      fetch_start = 1'b0;
      check("ma_err_hold", {err, err_code}, 3'b101);
      check("ma_ignore_req", mem_req, 1'b0);
      check("ma_pc_hold", pc, 32'h6);
      pc_load = 1'b1; pc_next = 32'h8000_0180;
      tick();
      pc_load = 1'b0;
      check("ma_recover", {err, err_code}, 3'b000);
      check("ma_recover_pc", pc, 32'h8000_0180);
      check("ma_recover_idle", {busy, IRWrite, mem_req}, 3'b000);

      // Timeout after 4 stalled WAIT cycles
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      check("to_req", mem_req, 1'b1);
      check("to_addr", mem_addr, 32'h8000_0180);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("to_still_wait", {busy, IRWrite, err}, 3'b100);
      end
      tick();
      check("to_err", err, 1'b1);
      check("to_code", err_code, 2'b10);
      check("to_req_drop", mem_req, 1'b0);
      check("to_no_irw", IRWrite, 1'b0);
      check("to_inst_hold", inst, 32'h1234_5678);
      pc_load = 1'b1; pc_next = 32'hFFFF_FFFC;
      tick();
      pc_load = 1'b0;
      check("to_recover", {err, err_code}, 3'b000);
      check("wr_pc_plus4", pc_plus4, 32'h0);

      // Wrap with zero-wait memory
      fetch_start = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
      tick();
      fetch_start = 1'b0;
      check("wr_addr", mem_addr, 32'hFFFF_FFFC);
      tick();
      mem_ready = 1'b0;
      check("wr_irw", IRWrite, 1'b1);
      check("wr_pc", pc, 32'h0);
      check("wr_no_err", err, 1'b0);
      tick();

      // Ready arriving in the cycle the count limit is reached wins
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      tick(); tick(); tick();
      mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_ready = 1'b0;
      check("rw_irw", IRWrite, 1'b1);
      check("rw_no_err", {err, err_code}, 3'b000);
      check("rw_inst", inst, 32'hDEAD_BEEF);
      check("rw_pc", pc, 32'h4);
      tick();

      // Async reset in the middle of WAIT
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      check("ab_req", mem_req, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("ab_req_drop", mem_req, 1'b0);
      check("ab_pc", pc, 32'h0);
      check("ab_inst", inst, 32'h0);
      check("ab_flags", {busy, IRWrite, err}, 3'b000);
      tick();
      rst = 1'b0;
      tick();
      check("ab_no_irw", IRWrite, 1'b0);
      check("ab_idle", {mem_req, busy}, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
